// File: rtl/dram_pkg.sv
// dram_pkg: shared types and timing defaults for the
// block-burst DRAM model and its cache-side users.
package dram_pkg;

  localparam int BLOCK_SIZE = 8;
  localparam int BEAT_W = 3;
  localparam int WORD_W = 32;
  localparam int CNT_W = 8;

  localparam int DEF_RD_LATENCY = 4;
  localparam int DEF_WR_LATENCY = 2;
  localparam int DEF_RD_GAP = 0;
  localparam int DEF_WR_GAP = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  function automatic logic [CNT_W-1:0] cnt_of(
    input int v
  );
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/dram_mem_array.sv
// dram_mem_array: single-port word array, synchronous
// write and combinational read, no reset on contents.
module dram_mem_array
  import dram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: block-burst memory behind the D-cache,
// with programmable latency and inter-beat gap.
module dram_ctrl #(
  parameter int BLOCK_SIZE = dram_pkg::BLOCK_SIZE,
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = dram_pkg::DEF_RD_LATENCY,
  parameter int WR_LATENCY = dram_pkg::DEF_WR_LATENCY,
  parameter int RD_GAP     = dram_pkg::DEF_RD_GAP,
  parameter int WR_GAP     = dram_pkg::DEF_WR_GAP
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        dram_wr_req,
  input  logic [31:0] dram_wr_addr,
  input  logic [31:0] dram_wr_data,
  output logic        dram_wr_val,
  input  logic        dram_rd_req,
  input  logic [31:0] dram_rd_addr,
  output logic [31:0] dram_rd_data,
  output logic        dram_rd_val,
  output logic        dram_busy
);

  import dram_pkg::*;

  localparam int BLK_W = ADDR_W - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e            st_q;
  op_e               op_q;
  logic [BLK_W-1:0]  blk_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              wr_val_q;
  logic              rd_val_q;

  logic              req_live;
  logic [CNT_W-1:0]  gap_len;
  logic [BEAT_W-1:0] beat_nx;
  logic [BEAT_W-1:0] mem_beat;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic              go_beat;
  logic              unused_addr;

  assign req_live = (op_q == OP_WR) ? dram_wr_req
                                    : dram_rd_req;
  assign gap_len  = (op_q == OP_WR) ? cnt_of(WR_GAP)
                                    : cnt_of(RD_GAP);
  assign beat_nx  = beat_q + BEAT_W'(1);

  // Reads look one beat ahead so data lands with val.
  assign mem_beat = (st_q == ST_BEAT && op_q == OP_RD)
                  ? beat_nx : beat_q;
  assign mem_addr = {blk_q, mem_beat};
  assign mem_we   = (st_q == ST_BEAT) && (op_q == OP_WR);

  assign unused_addr = ^{dram_wr_addr[31:ADDR_W],
                         dram_wr_addr[BEAT_W-1:0],
                         dram_rd_addr[31:ADDR_W],
                         dram_rd_addr[BEAT_W-1:0]};

  always_comb begin
    go_beat = 1'b0;
    unique case (st_q)
      ST_WAIT, ST_GAP:
        go_beat = req_live && (cnt_q <= ONE);
      ST_BEAT:
        go_beat = req_live && (beat_q != LAST_BEAT)
               && (gap_len == '0);
      default: go_beat = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      st_q      <= ST_IDLE;
      op_q      <= OP_RD;
      blk_q     <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      wr_val_q  <= 1'b0;
      rd_val_q  <= 1'b0;
    end else begin
      wr_val_q <= 1'b0;
      rd_val_q <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          beat_q <= '0;
          if (dram_wr_req) begin
            op_q  <= OP_WR;
            blk_q <= dram_wr_addr[ADDR_W-1:BEAT_W];
            cnt_q <= cnt_of(WR_LATENCY);
            st_q  <= ST_WAIT;
          end else if (dram_rd_req) begin
            op_q  <= OP_RD;
            blk_q <= dram_rd_addr[ADDR_W-1:BEAT_W];
            cnt_q <= cnt_of(RD_LATENCY);
            st_q  <= ST_WAIT;
          end
        end
        ST_WAIT, ST_GAP: begin
          if (!req_live) st_q <= ST_IDLE;
          else cnt_q <= cnt_q - ONE;
        end
        ST_BEAT: begin
          if (!req_live) begin
            st_q <= ST_IDLE;
          end else begin
            beat_q <= beat_nx;
            cnt_q  <= gap_len;
            st_q   <= (beat_q == LAST_BEAT) ? ST_DONE
                                            : ST_GAP;
          end
        end
        ST_DONE: begin
          if (!req_live) st_q <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
      if (go_beat) begin
        st_q     <= ST_BEAT;
        wr_val_q <= (op_q == OP_WR);
        rd_val_q <= (op_q == OP_RD);
        if (op_q == OP_RD) rd_data_q <= mem_rdata;
      end
    end
  end

  dram_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (dram_wr_data),
    .rdata_o (mem_rdata)
  );

  assign dram_wr_val  = wr_val_q;
  assign dram_rd_val  = rd_val_q;
  assign dram_rd_data = rd_data_q;
  assign dram_busy    = (st_q != ST_IDLE);

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed and random bursts against a
// word-array model with arithmetic beat timing.
module tb_dram_ctrl;

  import dram_pkg::*;

  localparam int AW    = 12;
  localparam int LAT_R = DEF_RD_LATENCY;
  localparam int LAT_W = DEF_WR_LATENCY;
  localparam int GAP_R = DEF_RD_GAP;
  localparam int GAP_W = DEF_WR_GAP;
  localparam logic [31:0] AMASK = 32'((1 << AW) - 1);

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        dram_wr_req = 1'b0;
  logic [31:0] dram_wr_addr = '0;
  logic [31:0] dram_wr_data;
  logic        dram_wr_val;
  logic        dram_rd_req = 1'b0;
  logic [31:0] dram_rd_addr = '0;
  logic [31:0] dram_rd_data;
  logic        dram_rd_val;
  logic        dram_busy;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] wwords [8];
  logic [3:0]  wcnt = '0;
  logic [31:0] wdata_r = '0;
  logic [31:0] ref_mem [int];

  int          rdc [$];
  logic [31:0] rdd [$];
  int          wrc [$];

  dram_ctrl #(
    .BLOCK_SIZE (8),
    .ADDR_W     (AW),
    .RD_LATENCY (LAT_R),
    .WR_LATENCY (LAT_W),
    .RD_GAP     (GAP_R),
    .WR_GAP     (GAP_W)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .dram_wr_req  (dram_wr_req),
    .dram_wr_addr (dram_wr_addr),
    .dram_wr_data (dram_wr_data),
    .dram_wr_val  (dram_wr_val),
    .dram_rd_req  (dram_rd_req),
    .dram_rd_addr (dram_rd_addr),
    .dram_rd_data (dram_rd_data),
    .dram_rd_val  (dram_rd_val),
    .dram_busy    (dram_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Cache side: counter bumps on val, data register follows one edge later.
  always @(posedge clock) begin
    if (!dram_wr_req) wcnt <= '0;
    else if (dram_wr_val === 1'b1) wcnt <= wcnt + 4'd1;
    wdata_r <= wwords[wcnt[2:0]];
  end
  assign dram_wr_data = wdata_r;

  function automatic int idx(input logic [31:0] a,
                             input int k);
    logic [31:0] m;
    m = (a & AMASK & ~32'h7) | 32'(k);
    return int'(m);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (dram_rd_val === 1'b1) begin
      rdc.push_back(cyc);
      rdd.push_back(dram_rd_data);
    end
    if (dram_wr_val === 1'b1) wrc.push_back(cyc);
  endtask

  task automatic wait_vals(input bit isw, input int n);
    int c;
    c = 0;
    while ((isw ? wrc.size() : rdc.size()) < n
           && c < 200) begin
      tick();
      c++;
    end
    chk(isw ? "wr_beats_seen" : "rd_beats_seen",
        32'((isw ? wrc.size() : rdc.size()) >= n), 1);
  endtask

  task automatic wr_burst(input logic [31:0] addr,
                          input bit chain,
                          input logic [31:0] raddr,
                          output int e0_rd);
    int b;
    int e0;
    b = wrc.size();
    dram_wr_addr = addr;
    dram_wr_req = 1'b1;
    e0 = cyc + 1;
    tick();
    chk("wr_busy", 32'(dram_busy), 1);
    wait_vals(1'b1, b + 8);
    for (int k = 0; k < 8; k++) begin
      if (wrc.size() > b + k)
        chk("wr_cyc", wrc[b+k],
            e0 + LAT_W + k * (GAP_W + 1));
      ref_mem[idx(addr, k)] = wwords[k];
    end
    tick();
    tick();
    dram_wr_req = 1'b0;
    e0_rd = 0;
    if (chain) begin
      dram_rd_addr = raddr;
      dram_rd_req = 1'b1;
      e0_rd = cyc + 2;
    end
    tick();
    chk("wr_extra", wrc.size(), b + 8);
  endtask

  task automatic rd_burst(input logic [31:0] addr,
                          input bit pre,
                          input int e0_in);
    int b;
    int e0;
    b = rdc.size();
    if (pre) begin
      e0 = e0_in;
    end else begin
      dram_rd_addr = addr;
      dram_rd_req = 1'b1;
      e0 = cyc + 1;
    end
    wait_vals(1'b0, b + 8);
    for (int k = 0; k < 8; k++) begin
      if (rdc.size() > b + k) begin
        chk("rd_cyc", rdc[b+k],
            e0 + LAT_R + k * (GAP_R + 1));
        chk("rd_dat", rdd[b+k], ref_mem[idx(addr, k)]);
      end
    end
    tick();
    tick();
    dram_rd_req = 1'b0;
    tick();
    chk("rd_idle", 32'(dram_busy), 0);
    tick();
    tick();
    chk("rd_extra", rdc.size(), b + 8);
  endtask

  initial begin
    int e;
    int b;
    logic [31:0] a;

    repeat (3) tick();
    chk("rst_wr_val", 32'(dram_wr_val), 0);
    chk("rst_rd_val", 32'(dram_rd_val), 0);
    chk("rst_rd_data", dram_rd_data, 0);
    chk("rst_busy", 32'(dram_busy), 0);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) wwords[k] = 32'hA0 + 32'(k);
    wr_burst(32'h100, 1'b0, 32'h0, e);
    rd_burst(32'h100, 1'b0, 0);

    for (int k = 0; k < 8; k++) wwords[k] = 32'hB0 + 32'(k);
    wr_burst(32'h208, 1'b0, 32'h0, e);
    rd_burst(32'h208, 1'b0, 0);

    // Write-back hands off to refill on the same edge.
    for (int k = 0; k < 8; k++) wwords[k] = $urandom;
    wr_burst(32'h3C0, 1'b1, 32'h208, e);
    rd_burst(32'h208, 1'b1, e);
    rd_burst(32'h3C0, 1'b0, 0);

    // Both requests together: write first.
    for (int k = 0; k < 8; k++) wwords[k] = $urandom;
    dram_rd_addr = 32'h3C0;
    dram_rd_req = 1'b1;
    b = rdc.size();
    wr_burst(32'h4A8, 1'b1, 32'h3C0, e);
    chk("sim_no_rd", rdc.size(), b);
    rd_burst(32'h3C0, 1'b1, e);
    rd_burst(32'h4A8, 1'b0, 0);

    // Alias and in-block wrap.
    for (int k = 0; k < 8; k++) wwords[k] = $urandom;
    wr_burst(32'h108, 1'b0, 32'h0, e);
    rd_burst(32'h0001_0100, 1'b0, 0);
    if (rdd.size() > 0)
      chk("alias_b7", rdd[rdd.size()-1], 32'hA7);

    // Reset after the third read beat.
    b = rdc.size();
    dram_rd_addr = 32'h100;
    dram_rd_req = 1'b1;
    wait_vals(1'b0, b + 3);
    rst = 1'b0;
    dram_rd_req = 1'b0;
    tick();
    chk("mid_rst_val", 32'(dram_rd_val), 0);
    chk("mid_rst_busy", 32'(dram_busy), 0);
    chk("mid_rst_data", dram_rd_data, 0);
    chk("mid_rst_beats", rdc.size(), b + 3);
    rst = 1'b1;
    tick();
    rd_burst(32'h100, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      a = $urandom & 32'hFFFF_FFF8;
      for (int k = 0; k < 8; k++) wwords[k] = $urandom;
      wr_burst(a, 1'b0, 32'h0, e);
      rd_burst(a, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
